// File: rtl/core_pkg.sv
// Shared EX-stage encodings: ALU opcodes, multiply/divide op select and sequencer states.
package core_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_LUI   = 4'b1000;
    localparam logic [3:0] ALU_PASSA = 4'b1010;
    localparam logic [3:0] ALU_PASSB = 4'b1011;

    localparam logic OP_MULTU = 1'b0;
    localparam logic OP_DIVU  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_ctrl.sv
// MULTU/DIVU sequencer borrowing the EX-stage ALU: one add (shift-add) or subtract
// (restoring divide) per cycle for WIDTH iterations, result returned in hi/lo.
module muldiv_ctrl
    import core_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [3:0]       alu_ct,
    output logic [WIDTH-1:0] alu_src1,
    output logic [WIDTH-1:0] alu_src2,
    input  logic [WIDTH-1:0] alu_res,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH);

    // Handshake: start is a strobe taken only while busy is low (never queued);
    // done pulses for one cycle and hi/lo then hold until the next accepted start.
    md_state_e        r_state;
    logic             r_op;
    logic             r_busy;
    logic             r_done;
    logic [3:0]       r_alu_ct;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opnd;

    logic [WIDTH-1:0] w_rem;
    logic             w_carry;
    logic             w_ge;

    assign w_rem   = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
    assign w_carry = (alu_res < r_hi);
    // The shifted-out msb means the partial remainder already exceeds any divisor.
    assign w_ge    = r_hi[WIDTH-1] | (w_rem >= r_opnd);

    assign alu_src1  = (r_state == RUN && r_op == OP_DIVU) ? w_rem : r_hi;
    assign alu_src2  = r_opnd;
    assign alu_ct    = r_alu_ct;
    assign busy      = r_busy;
    assign done      = r_done;
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_op     <= OP_MULTU;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_alu_ct <= ALU_PASSA;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
        end else begin
            r_done <= 1'b0;
            if (flush) begin
                r_state  <= IDLE;
                r_busy   <= 1'b0;
                r_alu_ct <= ALU_PASSA;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_op   <= op;
                            r_opnd <= (op == OP_DIVU) ? src2 : src1;
                            r_cnt  <= CW'(WIDTH - 1);
                            r_busy <= 1'b1;
                            if (op == OP_DIVU && src2 == '0) begin
                                r_hi     <= src1;
                                r_lo     <= '1;
                                r_state  <= DONE;
                                r_done   <= 1'b1;
                                r_alu_ct <= ALU_PASSA;
                            end else begin
                                r_hi     <= '0;
                                r_lo     <= (op == OP_DIVU) ? src1 : src2;
                                r_state  <= RUN;
                                r_alu_ct <= (op == OP_DIVU) ? ALU_SUB : ALU_ADD;
                            end
                        end
                    end
                    RUN: begin
                        if (r_op == OP_MULTU) begin
                            if (r_lo[0])
                                {r_hi, r_lo} <= {w_carry, alu_res, r_lo[WIDTH-1:1]};
                            else
                                {r_hi, r_lo} <= {1'b0, r_hi, r_lo[WIDTH-1:1]};
                        end else begin
                            if (w_ge) begin
                                r_hi <= alu_res;
                                r_lo <= {r_lo[WIDTH-2:0], 1'b1};
                            end else begin
                                r_hi <= w_rem;
                                r_lo <= {r_lo[WIDTH-2:0], 1'b0};
                            end
                        end
                        if (r_cnt == '0) begin
                            r_state  <= DONE;
                            r_done   <= 1'b1;
                            r_alu_ct <= ALU_PASSA;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state  <= IDLE;
                        r_busy   <= 1'b0;
                        r_alu_ct <= ALU_PASSA;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed and random MULTU/DIVU against an arithmetic model.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [3:0]  alu_ct;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [31:0] alu_res;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_q[$];

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .src1(src1), .src2(src2), .flush(flush),
        .busy(busy), .done(done), .hi(hi), .lo(lo),
        .alu_ct(alu_ct), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_res(alu_res), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // EX-stage ALU as seen by the controller
    always_comb begin
        alu_res = alu_src1;
        case (alu_ct)
            4'b0010: alu_res = alu_src1 + alu_src2;
            4'b0110: alu_res = alu_src1 - alu_src2;
            default: alu_res = alu_src1;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic o, input logic [31:0] a, input logic [31:0] b);
        if (o == 1'b0) return 64'(a) * 64'(b);
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_hilo"}, {hi, lo}, 64'd0);
        check({tag, "_alu_ct"}, 64'(alu_ct), 64'hA);
        check({tag, "_alu_src"}, {alu_src1, alu_src2}, 64'd0);
        check({tag, "_state"}, 64'(dbg_state), 64'd0);
    endtask

    // Issue one request at edge 0 and watch cycles 1..40.
    // poke_cyc: start pulse with other operands; flush_cyc / rst_cyc: abort in that cycle.
    task automatic run_op(input string tag, input logic o, input logic [31:0] a, input logic [31:0] b,
                          input int poke_cyc, input int flush_cyc, input int rst_cyc);
        int          lat = 0;
        int          busy_n = 0;
        int          done_n = 0;
        int          stop_cyc;
        logic [63:0] got = '0;
        logic [63:0] exp;
        logic [3:0]  ct1 = '0;
        logic        div0;
        div0 = (o == 1'b1) && (b == 32'd0);
        exp_q.push_back(ref_result(o, a, b));
        @(negedge clk);
        op = o; src1 = a; src2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc == 1) ct1 = alu_ct;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (lat == 0) lat = cyc;
                got = {hi, lo};
            end
            if (cyc == poke_cyc) begin
                start = 1'b1; src1 = a + 32'd5; src2 = b + 32'd3;
            end
            if (cyc == flush_cyc) flush = 1'b1;
            if (cyc == rst_cyc) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs({tag, "_midrst"});
            end
            @(negedge clk);
            start = 1'b0; flush = 1'b0; rst_n = 1'b1;
        end
        exp = exp_q.pop_front();
        stop_cyc = (flush_cyc > 0) ? flush_cyc : rst_cyc;
        if (stop_cyc == 0) begin
            check({tag, "_latency"}, 64'(lat), div0 ? 64'd1 : 64'd33);
            check({tag, "_busy_cycles"}, 64'(busy_n), div0 ? 64'd1 : 64'd33);
            check({tag, "_done_pulses"}, 64'(done_n), 64'd1);
            check({tag, "_result"}, got, exp);
            check({tag, "_held"}, {hi, lo}, exp);
            check({tag, "_alu_ct_run"}, 64'(ct1), div0 ? 64'hA : (o ? 64'h6 : 64'h2));
        end else begin
            check({tag, "_done_pulses"}, 64'(done_n), 64'd0);
            check({tag, "_busy_cycles"}, 64'(busy_n), 64'(stop_cyc));
        end
        check({tag, "_idle_alu_ct"}, 64'(alu_ct), 64'hA);
    endtask

    initial begin
        logic        ro;
        logic [31:0] ra;
        logic [31:0] rb;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mul_7x6",      1'b0, 32'd7,          32'd6,          0, 0, 0);
        run_op("mul_max",      1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  0, 0, 0);
        run_op("div_100_7",    1'b1, 32'd100,        32'd7,          0, 0, 0);
        run_op("div_max_1",    1'b1, 32'hFFFF_FFFF,  32'd1,          0, 0, 0);
        run_op("div_3_msb",    1'b1, 32'd3,          32'h8000_0000,  0, 0, 0);
        run_op("div_5_0",      1'b1, 32'd5,          32'd0,          0, 0, 0);
        run_op("div0_b2b",     1'b1, 32'hDEAD_BEEF,  32'd0,          0, 0, 0);
        run_op("mul_poke",     1'b0, 32'd1234,       32'd5678,       10, 0, 0);
        run_op("mul_flush",    1'b0, 32'd99,         32'd77,         0, 15, 0);
        run_op("mul_3x3",      1'b0, 32'd3,          32'd3,          0, 0, 0);
        run_op("div_rst",      1'b1, 32'd1000,       32'd3,          0, 0, 20);
        run_op("div_post_rst", 1'b1, 32'd1000,       32'd3,          0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            ro = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
            run_op("rand", ro, ra, rb, 0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
